song_note_sequencer: RTL
========================

SONG_NOTE_SEQUENCER -- requirements
Module: song_note_sequencer

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 The module SHALL have the port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-003 The module SHALL have the port play, input, 1 bit: 1 = sequence notes, 0 = pause.
REQ-004 The module SHALL have the port song, input, 2 bits: song select; 4 songs of 32 entries each.
REQ-005 The module SHALL have the port rom_addr, output, 7 bits: song ROM address, equal to {song, index[4:0]}.
REQ-006 The module SHALL have the port rom_data, input, 16 bits: ROM word with 1-cycle synchronous read latency. Fields: [15] end marker, [14:13] stereo side, [12:7] note, [6:1] duration, [0] ignored.
REQ-007 The module SHALL have the port note_to_load, output, 6 bits: registered note field.
REQ-008 The module SHALL have the port duration_to_load, output, 6 bits: registered duration field.
REQ-009 The module SHALL have the port stereo_side_to_load, output, 2 bits: registered stereo one-hot field.
REQ-010 The module SHALL have the port load_new_note, output, 1 bit: one-cycle pulse; the note fields are valid while it is high.
REQ-011 The module SHALL have the port done_with_note, input, 1 bit: pulse from the note player indicating the current note has finished.
REQ-012 The module SHALL have the port song_done, output, 1 bit: one-cycle pulse at the end of the song.

Function
REQ-013 The module SHALL implement the states IDLE, FETCH, DECODE, LOAD, WAIT_DONE and END.
REQ-014 IDLE SHALL go to FETCH when play=1 and otherwise hold.
REQ-015 FETCH SHALL present rom_addr and go to DECODE on the next cycle unconditionally.
REQ-016 In DECODE with end marker=0, the module SHALL register the note, duration and stereo fields and go to LOAD.
REQ-017 In DECODE with end marker=1, the module SHALL leave the field registers unchanged and go to END.
REQ-018 LOAD SHALL assert load_new_note for exactly one cycle and go to WAIT_DONE.
REQ-019 done_with_note SHALL be ignored in every state except WAIT_DONE.
REQ-020 In WAIT_DONE, done_with_note=1 SHALL increment the index. If the index was 31, the module SHALL go to END; otherwise, if play=1 it SHALL go to FETCH, and if play=0 it SHALL go to IDLE.
REQ-021 END SHALL pulse song_done for one cycle and then behave per the configuration (REQ-031/REQ-032).
REQ-022 Latency: play rising in IDLE at edge t SHALL produce load_new_note=1 in the cycle after edge t+3 (FETCH, DECODE, LOAD).
REQ-023 play=0 SHALL never abort a note already loaded; pausing the sounding note is the note player's job.
REQ-024 A song change SHALL be detected by comparing song against its value registered on the previous cycle.
REQ-025 On a song change in any state, the module SHALL clear the index to 0 and go to IDLE; a load_new_note pulse scheduled for that cycle SHALL be suppressed.
REQ-026 An entry with duration 0 SHALL be loaded normally, and the module SHALL wait for done_with_note as usual.
REQ-027 The index SHALL be 5 bits; incrementing from 31 SHALL wrap to 0, and that wrap SHALL coincide with the entry to END.

Reset
REQ-028 While reset=0, the module SHALL force: state IDLE, index 0, rom_addr {song,5'd0}, note/duration/stereo outputs 0, load_new_note 0, song_done 0.
REQ-029 Reset asserted mid-operation (any state) SHALL take effect asynchronously, with no load or song_done pulse emitted.
REQ-030 After reset is released, the first action SHALL require play=1.

Configuration
REQ-031 With macro SONG_REPEAT_EN defined, END SHALL clear the index to 0 and go to FETCH if play=1, or to IDLE if play=0, so the song loops.
REQ-032 With SONG_REPEAT_EN undefined, END SHALL hold until a song change or reset; play toggling SHALL have no effect while in END.

Verification
REQ-033 Scenario: song=1, entry0 = note 6'd20, duration 6'd12, side 2'b01, play rises -> load_new_note one cycle after edge t+3 with note_to_load=20, duration_to_load=12, stereo_side_to_load=01, rom_addr=7'h20.
REQ-034 Scenario: done_with_note pulse in WAIT_DONE with play=1 -> rom_addr=7'h21, next load_new_note 3 cycles later.
REQ-035 Scenario: entry2 end marker=1 -> no third load, song_done pulses once; without SONG_REPEAT_EN the module stays in END over 100 cycles; with the macro, the next load shows the entry0 fields.
REQ-036 Scenario: all 32 entries with no end marker -> song_done after the 32nd done_with_note, index back to 0.
REQ-037 Scenario: song changed 1->3 during WAIT_DONE -> IDLE, then rom_addr=7'h60 and the next load reads entry 0 of song 3.
REQ-038 Scenario: reset driven to 0 during LOAD -> all outputs 0 immediately, no pulse; done_with_note pulses in IDLE are ignored.

Source files
------------

// File: rtl/song_note_sequencer_if.sv
// rtl/song_note_sequencer_if.sv - play/song control, song ROM port and note-player handshake
interface song_note_sequencer_if;
  logic        play;
  logic [1:0]  song;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic [1:0]  stereo_side_to_load;
  logic        load_new_note;
  logic        done_with_note;
  logic        song_done;

  modport master (
    output play, song, rom_data, done_with_note,
    input  rom_addr, note_to_load, duration_to_load, stereo_side_to_load,
           load_new_note, song_done
  );

  modport slave (
    input  play, song, rom_data, done_with_note,
    output rom_addr, note_to_load, duration_to_load, stereo_side_to_load,
           load_new_note, song_done
  );
endinterface

// File: rtl/song_note_sequencer.sv
// rtl/song_note_sequencer.sv - walks a 32-entry song ROM and hands notes to the note player
// Optional SONG_REPEAT_EN: the song loops from entry 0 instead of holding at its end.
module song_note_sequencer (
  input  logic                         clk,
  input  logic                         reset,
  song_note_sequencer_if.slave         bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LOAD, S_WAIT_DONE, S_END
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  index_q, index_d;
  logic [5:0]  note_q, note_d;
  logic [5:0]  dur_q, dur_d;
  logic [1:0]  side_q, side_d;
  logic [1:0]  song_q;
  logic        song_vld_q;
  logic        end_seen_q;
  logic        song_chg;

  // song_vld_q keeps the first cycle after reset from looking like a song change
  assign song_chg = song_vld_q && (bus.song != song_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      note_q     <= '0;
      dur_q      <= '0;
      side_q     <= '0;
      song_q     <= '0;
      song_vld_q <= 1'b0;
      end_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      side_q     <= side_d;
      song_q     <= bus.song;
      song_vld_q <= 1'b1;
      end_seen_q <= (state_q == S_END);
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    note_d  = note_q;
    dur_d   = dur_q;
    side_d  = side_q;
    if (song_chg) begin
      state_d = S_IDLE;
      index_d = '0;
    end else begin
      case (state_q)
        S_IDLE:   if (bus.play) state_d = S_FETCH;
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          if (bus.rom_data[15]) begin
            state_d = S_END;
          end else begin
            side_d  = bus.rom_data[14:13];
            note_d  = bus.rom_data[12:7];
            dur_d   = bus.rom_data[6:1];
            state_d = S_LOAD;
          end
        end
        S_LOAD:   state_d = S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (bus.done_with_note) begin
            index_d = index_q + 5'd1;
            if (index_q == 5'd31) state_d = S_END;
            else if (bus.play)    state_d = S_FETCH;
            else                  state_d = S_IDLE;
          end
        end
        S_END: begin
`ifdef SONG_REPEAT_EN
          index_d = '0;
          state_d = bus.play ? S_FETCH : S_IDLE;
`else
          state_d = S_END;
`endif
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // A song change in the LOAD cycle cancels that cycle's pulse
  assign bus.load_new_note       = (state_q == S_LOAD) && !song_chg;
  assign bus.song_done           = (state_q == S_END) && !end_seen_q;
  assign bus.rom_addr            = {bus.song, index_q};
  assign bus.note_to_load        = note_q;
  assign bus.duration_to_load    = dur_q;
  assign bus.stereo_side_to_load = side_q;

endmodule
